accel_spi_reader: RTL and testbench

Polls the board accelerometer (ADXL362) over SPI and converts the X/Y tilt readings into the signed 4-bit tilt codes `spi_x_out`/`spi_y_out` that drive tilt-controlled player movement. It sits directly upstream of the player movement stage: one reader instance feeds both tilt code buses. It configures the sensor once after reset, then reads X and Y at a fixed sample rate.

---
 rtl/accel_spi_reader.sv | 142 ++++++++++++++
 tb/tb_accel_spi_reader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/accel_spi_reader.sv
// accel_spi_reader
//   Polls an ADXL362 accelerometer over SPI (mode 0). After reset it waits
//   PWRUP cycles, writes POWER_CTL = measurement mode once, then reads
//   XDATA/YDATA every SAMPLE_DIV cycles. Each 8-bit sample is reduced to a
//   signed 4-bit tilt code (sample >>> SHIFT).
// Ports
//   clk, rst        : system clock, synchronous active-high reset
//   miso            : sensor data out
//   sclk/mosi/cs_n  : SPI master outputs (sclk idles low, MSB first)
//   spi_x_out/_y_out: signed 4-bit tilt codes, updated together
//   sample_valid    : one-cycle pulse when new codes are presented
module accel_spi_reader #(
  parameter int CLK_DIV    = 50,
  parameter int SAMPLE_DIV = 1000000,
  parameter int PWRUP      = 500000,
  parameter int SHIFT      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  output logic [3:0] spi_x_out,
  output logic [3:0] spi_y_out,
  output logic       sample_valid
);

  typedef enum logic [2:0] {PWR_WAIT, CFG, GAP, IDLE, READ} state_e;
  typedef enum logic [1:0] {PH_LO, PH_HI, PH_TAIL} phase_e;

  localparam int DW   = $clog2(CLK_DIV);
  localparam int WMAX = (PWRUP > 2*CLK_DIV) ? PWRUP : 2*CLK_DIV;
  localparam int WW   = $clog2(WMAX + 1);
  localparam int SW   = $clog2(SAMPLE_DIV + 1);

  // Frames are left-aligned; CFG only shifts out the top 24 bits.
  localparam logic [31:0] CFG_W = 32'h0A2D_0200;
  localparam logic [31:0] RD_W  = 32'h0B08_0000;

  state_e        state_q;
  phase_e        ph_q;
  logic [WW-1:0] wait_q;   // power-up and gap counter
  logic [DW-1:0] div_q;    // position within an SCLK half-period
  logic [SW-1:0] smp_q;    // cycles since last READ cs_n fall, saturating
  logic [5:0]    bits_q;   // bits still to finish in this frame
  logic [31:0]   tx_q;
  logic [15:0]   rx_q;     // only XDATA/YDATA (last 16 bits) are kept

  logic [15:0] rx_d;
  logic [31:0] xfer_w;
  logic        div_last, smp_full, gap_done, go_cfg, go_read;

  assign rx_d     = {rx_q[14:0], miso};
  assign div_last = (div_q == DW'(CLK_DIV - 1));
  assign smp_full = (smp_q == SW'(SAMPLE_DIV));
  assign gap_done = (wait_q == WW'(2*CLK_DIV - 1));
  assign go_cfg   = (state_q == PWR_WAIT) && (wait_q == WW'(PWRUP - 1));
  // A late gap with an already-expired timer goes straight into READ,
  // so back-to-back reads are spaced by exactly transaction + gap.
  assign go_read  = smp_full && ((state_q == IDLE) || (state_q == GAP && gap_done));
  assign xfer_w   = go_cfg ? CFG_W : RD_W;

  always_ff @(posedge clk) begin
    sample_valid <= 1'b0;
    if (rst) begin
      state_q   <= PWR_WAIT;
      ph_q      <= PH_LO;
      wait_q    <= '0;
      div_q     <= '0;
      smp_q     <= SW'(SAMPLE_DIV);  // first READ follows the CFG gap directly
      bits_q    <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      cs_n      <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      spi_x_out <= '0;
      spi_y_out <= '0;
    end else begin
      if (!smp_full) smp_q <= smp_q + SW'(1);

      case (state_q)
        PWR_WAIT: wait_q <= wait_q + WW'(1);
        CFG, READ: begin
          if (!div_last) begin
            div_q <= div_q + DW'(1);
          end else begin
            div_q <= '0;
            case (ph_q)
              PH_LO: begin
                sclk <= 1'b1;
                rx_q <= rx_d;
                ph_q <= PH_HI;
              end
              PH_HI: begin
                sclk <= 1'b0;
                if (bits_q == 6'd1) begin
                  ph_q <= PH_TAIL;
                end else begin
                  mosi   <= tx_q[31];
                  tx_q   <= {tx_q[30:0], 1'b0};
                  bits_q <= bits_q - 6'd1;
                  ph_q   <= PH_LO;
                end
              end
              default: begin
                // End of frame: release cs_n and publish both codes at once.
                cs_n    <= 1'b1;
                wait_q  <= '0;
                state_q <= GAP;
                if (state_q == READ) begin
                  spi_x_out    <= 4'($signed(rx_q[15:8]) >>> SHIFT);
                  spi_y_out    <= 4'($signed(rx_q[7:0]) >>> SHIFT);
                  sample_valid <= 1'b1;
                end
              end
            endcase
          end
        end
        GAP: begin
          if (gap_done) state_q <= IDLE;
          else          wait_q  <= wait_q + WW'(1);
        end
        default: ;
      endcase

      if (go_cfg || go_read) begin
        state_q <= go_cfg ? CFG : READ;
        cs_n    <= 1'b0;
        sclk    <= 1'b0;
        mosi    <= xfer_w[31];
        tx_q    <= {xfer_w[30:0], 1'b0};
        bits_q  <= go_cfg ? 6'd24 : 6'd32;
        ph_q    <= PH_LO;
        div_q   <= '0;
        if (go_read) smp_q <= SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader: three instances with CLK_DIV=2, PWRUP=10.
//   u_a: SHIFT=4, SAMPLE_DIV=300 (main DUT, driven by the MISO model)
//   u_b: SHIFT=5, SAMPLE_DIV=300 (same stimulus, runs in lockstep with u_a)
//   u_c: SHIFT=4, SAMPLE_DIV=20  (read period limited by transaction + gap)
module tb_accel_spi_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic miso = 1'b0;
  logic miso_c = 1'b0;

  logic sclk_a, mosi_a, cs_a, sv_a;
  logic sclk_b, mosi_b, cs_b, sv_b;
  logic sclk_c, mosi_c, cs_c, sv_c;
  logic [3:0] x_a, y_a, x_b, y_b, x_c, y_c;

  always #5 clk = ~clk;

  accel_spi_reader #(.CLK_DIV(2), .SAMPLE_DIV(300), .PWRUP(10), .SHIFT(4)) u_a (
    .clk(clk), .rst(rst), .miso(miso), .sclk(sclk_a), .mosi(mosi_a), .cs_n(cs_a),
    .spi_x_out(x_a), .spi_y_out(y_a), .sample_valid(sv_a));
  accel_spi_reader #(.CLK_DIV(2), .SAMPLE_DIV(300), .PWRUP(10), .SHIFT(5)) u_b (
    .clk(clk), .rst(rst), .miso(miso), .sclk(sclk_b), .mosi(mosi_b), .cs_n(cs_b),
    .spi_x_out(x_b), .spi_y_out(y_b), .sample_valid(sv_b));
  accel_spi_reader #(.CLK_DIV(2), .SAMPLE_DIV(20), .PWRUP(10), .SHIFT(4)) u_c (
    .clk(clk), .rst(rst), .miso(miso_c), .sclk(sclk_c), .mosi(mosi_c), .cs_n(cs_c),
    .spi_x_out(x_c), .spi_y_out(y_c), .sample_valid(sv_c));

  typedef struct packed {
    logic [3:0] xa, ya, xb, yb;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle counter and SPI monitor / MISO model for u_a
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [31:0] resp = '0;        // word the sensor model returns, byte 0 first
  logic [31:0] tx_w = '0, last_tx = '0;
  int nb = 0, last_nb = 0, low_len = 0, last_low = 0, bidx = 0;
  int hi_run = 0, txn_cnt = 0, sv_cnt = 0, f_cyc = 0, f_prev = 0;
  logic p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    if (cs_a) chk("sclk_idle_a", {31'd0, sclk_a}, 0);
    if (p_sclk && sclk_a) chk("mosi_hold_a", {31'd0, mosi_a}, {31'd0, p_mosi});
    chk("b_lockstep", {29'd0, sclk_b, mosi_b, cs_b}, {29'd0, sclk_a, mosi_a, cs_a});

    if (!cs_a && p_cs) begin
      chk("cs_gap", {31'd0, hi_run >= 4}, 1);
      chk("sclk_at_fall", {31'd0, sclk_a}, 0);
      f_prev = f_cyc; f_cyc = cyc;
      tx_w = '0; nb = 0; low_len = 0; bidx = 0;
    end
    if (!cs_a) begin low_len++; hi_run = 0; end
    else hi_run++;
    if (!p_sclk && sclk_a && !cs_a) begin
      tx_w = {tx_w[30:0], mosi_a}; nb++; bidx++;
    end
    if (cs_a && !p_cs) begin
      last_tx = tx_w; last_nb = nb; last_low = low_len; txn_cnt++;
      chk("sv_at_end", {31'd0, sv_a}, {31'd0, nb == 32});
    end
    if (sv_a) begin
      sv_cnt++;
      chk("sv_at_cs_rise", {31'd0, cs_a && !p_cs}, 1);
      chk("sv_b", {31'd0, sv_b}, 1);
      chk("sv_expected", {31'd0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("x_a", {28'd0, x_a}, {28'd0, e.xa});
        chk("y_a", {28'd0, y_a}, {28'd0, e.ya});
        chk("x_b", {28'd0, x_b}, {28'd0, e.xb});
        chk("y_b", {28'd0, y_b}, {28'd0, e.yb});
      end
    end
    miso = (!cs_a && bidx < 32) ? resp[31 - bidx] : 1'b0;
    p_cs = cs_a; p_sclk = sclk_a; p_mosi = mosi_a;
  end

  // Monitor for u_c: read period and basic protocol
  int c_fall = 0, c_per = 0;
  logic pc_cs = 1'b1, pc_sclk = 1'b0, pc_mosi = 1'b0;
  always @(negedge clk) begin
    if (cs_c) chk("sclk_idle_c", {31'd0, sclk_c}, 0);
    if (pc_sclk && sclk_c) chk("mosi_hold_c", {31'd0, mosi_c}, {31'd0, pc_mosi});
    if (!cs_c && pc_cs) begin c_per = cyc - c_fall; c_fall = cyc; end
    if (sv_c) chk("codes_c", {24'd0, x_c, y_c}, 0);
    pc_cs = cs_c; pc_sclk = sclk_c; pc_mosi = mosi_c;
  end

  task automatic wait_txn(input string tag, input int bound);
    int start = txn_cnt;
    int n = 0;
    while (txn_cnt == start && n < bound) begin @(negedge clk); n++; end
    chk({tag, "_timeout"}, {31'd0, txn_cnt != start}, 1);
  endtask

  task automatic cnt_to_fall(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (cs_a && n < 1000);
  endtask

  int n;

  initial begin
    rst = 1'b1;
    resp = {16'h0, 8'h35, 8'hD0};
    exp_q.push_back('{4'h3, 4'hD, 4'h1, 4'hE});
    repeat (3) @(negedge clk);
    chk("rst_cs_n", {31'd0, cs_a}, 1);
    chk("rst_sclk", {31'd0, sclk_a}, 0);
    chk("rst_mosi", {31'd0, mosi_a}, 0);
    chk("rst_x", {28'd0, x_a}, 0);
    chk("rst_y", {28'd0, y_a}, 0);
    chk("rst_sv", {31'd0, sv_a}, 0);

    // Power-up wait and configuration write
    rst = 1'b0;
    cnt_to_fall(n);
    chk("pwrup_delay", n, 10);
    wait_txn("cfg", 400);
    chk("cfg_tx", last_tx, 32'h000A_2D02);
    chk("cfg_bits", last_nb, 24);
    chk("cfg_low", last_low, 98);
    chk("cfg_no_sv", sv_cnt, 0);

    // First read: X=0x35, Y=0xD0
    wait_txn("rd1", 600);
    chk("rd_tx", last_tx, 32'h0B08_0000);
    chk("rd_bits", last_nb, 32);
    chk("rd_low", last_low, 130);
    chk("rd1_sv", sv_cnt, 1);

    // Extremes: X=0x7F, Y=0x80
    resp = {16'h0, 8'h7F, 8'h80};
    exp_q.push_back('{4'h7, 4'h8, 4'h3, 4'hC});
    wait_txn("rd2", 600);
    chk("period_300", f_cyc - f_prev, 300);
    chk("period_min", c_per, 134);
    chk("rd2_sv", sv_cnt, 2);

    // X=0x60, Y=0xA0 (SHIFT=5 gives 3 and -3)
    resp = {16'h0, 8'h60, 8'hA0};
    exp_q.push_back('{4'h6, 4'hA, 4'h3, 4'hD});
    wait_txn("rd3", 600);
    chk("rd3_sv", sv_cnt, 3);

    // Reset in the middle of a read; the partial sample must be dropped
    resp = {16'h0, 8'h7F, 8'h7F};
    n = 0;
    while (cs_a && n < 600) begin @(negedge clk); n++; end
    chk("rd4_start", {31'd0, cs_a}, 0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cs_n", {31'd0, cs_a}, 1);
    chk("mid_rst_sclk", {31'd0, sclk_a}, 0);
    chk("mid_rst_x", {28'd0, x_a}, 0);
    chk("mid_rst_y", {28'd0, y_a}, 0);
    chk("mid_rst_sv", {31'd0, sv_a}, 0);
    resp = {16'h0, 8'h10, 8'hFF};
    exp_q.push_back('{4'h1, 4'hF, 4'h0, 4'hF});
    @(negedge clk);
    rst = 1'b0;
    cnt_to_fall(n);
    chk("pwrup_delay2", n, 10);
    wait_txn("cfg2", 400);
    chk("cfg2_tx", last_tx, 32'h000A_2D02);
    chk("cfg2_bits", last_nb, 24);
    chk("cfg2_no_sv", sv_cnt, 3);
    wait_txn("rd5", 600);
    chk("rd5_sv", sv_cnt, 4);
    chk("exp_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
